// File: rtl/chenillard_nios2_gen2_0_cpu_ocimem_arbiter_pkg.sv
// Shared types and jdo field positions for the OCI RAM arbiter and its JTAG request tracker.
package chenillard_nios2_gen2_0_cpu_ocimem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AV_RD = 2'd1,
        JT_RD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_LDADDR = 2'd1,
        OP_RD     = 2'd2,
        OP_WR     = 2'd3
    } jop_t;

    localparam int JDO_RD_FLAG  = 34;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_ADDR_LSB = 17;

    localparam logic [3:0] BE_ALL = 4'hF;

    // True when two or more of the three JTAG pulses are high together.
    function automatic logic multi_hot3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/chenillard_nios2_gen2_0_cpu_ocimem_jtag_req.sv
// JTAG request tracker: pulse priority, one-deep pending slot, sticky overrun and the
// auto-increment address counter that JTAG reads and writes walk through.
module chenillard_nios2_gen2_0_cpu_ocimem_jtag_req
    import chenillard_nios2_gen2_0_cpu_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              debugack,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              consume,
    output logic              pend_valid,
    output jop_t              pend_op,
    output logic [31:0]       pend_data,
    output logic [ADDR_W-1:0] jt_addr,
    output logic              incoming,
    output logic              jtag_overrun
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              pend_valid_r;
    jop_t              pend_op_r;
    logic              pend_ld_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [31:0]       pend_data_r;
    logic [ADDR_W-1:0] addr_r;
    logic              overrun_r;

    logic [2:0]        pulses_s;
    logic              accept_s;
    logic              full_s;
    jop_t              new_op_s;
    logic              new_ld_s;
    logic [ADDR_W-1:0] jt_addr_s;
    logic              unused_jdo_s;

    assign pulses_s     = {take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a};
    assign accept_s     = debugack & (|pulses_s);
    assign full_s       = pend_valid_r & ~consume;
    assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

    // Decode the highest-priority pulse (b > a > no_action_a) into an op for the slot.
    always_comb begin
        new_op_s = OP_NONE;
        new_ld_s = 1'b0;
        if (take_action_ocimem_b) begin
            new_op_s = OP_WR;
        end else if (take_action_ocimem_a) begin
            new_op_s = jdo[JDO_RD_FLAG] ? OP_RD : OP_LDADDR;
            new_ld_s = 1'b1;
        end else if (take_no_action_ocimem_a) begin
            new_op_s = OP_RD;
        end else begin
            new_op_s = OP_NONE;
        end
    end

    // RAM address for the pending op: a loaded address, the counter for writes, or the
    // pre-incremented counter for streaming reads.
    always_comb begin
        jt_addr_s = addr_r;
        if (pend_ld_r) begin
            jt_addr_s = pend_addr_r;
        end else if (pend_op_r == OP_WR) begin
            jt_addr_s = addr_r;
        end else begin
            jt_addr_s = addr_r + ADDR_ONE;
        end
    end

    // Pending slot, address counter and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_r <= 1'b0;
            pend_op_r    <= OP_NONE;
            pend_ld_r    <= 1'b0;
            pend_addr_r  <= '0;
            pend_data_r  <= 32'h0000_0000;
            addr_r       <= '0;
            overrun_r    <= 1'b0;
        end else begin
            if (consume && pend_valid_r) begin
                pend_valid_r <= 1'b0;
                addr_r       <= (pend_op_r == OP_WR) ? (addr_r + ADDR_ONE) : jt_addr_s;
            end
            if (accept_s && !full_s) begin
                pend_valid_r <= 1'b1;
                pend_op_r    <= new_op_s;
                pend_ld_r    <= new_ld_s;
                pend_addr_r  <= jdo[JDO_ADDR_LSB +: ADDR_W];
                pend_data_r  <= jdo[JDO_DATA_LSB +: 32];
            end
            if (accept_s && (full_s || multi_hot3(pulses_s))) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign pend_valid   = pend_valid_r;
    assign pend_op      = pend_op_r;
    assign pend_data    = pend_data_r;
    assign jt_addr      = jt_addr_s;
    assign incoming     = accept_s;
    assign jtag_overrun = overrun_r;

endmodule

// File: rtl/chenillard_nios2_gen2_0_cpu_ocimem_arbiter.sv
// OCI RAM port arbiter: pending JTAG ops take the single RAM port ahead of the Avalon
// debug_mem slave; JTAG read data lands in MonDReg, Avalon read data in av_readdata.
module chenillard_nios2_gen2_0_cpu_ocimem_arbiter
    import chenillard_nios2_gen2_0_cpu_ocimem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    input  logic              debugack,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_byteen,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_r;
    state_t            next_s;
    logic              av_done_r;
    logic [DATA_W-1:0] av_readdata_r;
    logic [DATA_W-1:0] mon_dreg_r;

    logic              pend_valid_s;
    jop_t              pend_op_s;
    logic [31:0]       pend_data_s;
    logic [ADDR_W-1:0] jt_addr_s;
    logic              incoming_s;
    logic              consume_s;
    logic              ram_rden_s;
    logic              ram_wren_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [3:0]        ram_byteen_s;
    logic              wait_s;

    chenillard_nios2_gen2_0_cpu_ocimem_jtag_req #(
        .ADDR_W (ADDR_W)
    ) u_jtag_req (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .debugack                (debugack),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .consume                 (consume_s),
        .pend_valid              (pend_valid_s),
        .pend_op                 (pend_op_s),
        .pend_data               (pend_data_s),
        .jt_addr                 (jt_addr_s),
        .incoming                (incoming_s),
        .jtag_overrun            (jtag_overrun)
    );

    // Grant and RAM muxing; a JTAG pulse arriving this cycle already holds off Avalon.
    always_comb begin
        next_s       = state_r;
        consume_s    = 1'b0;
        ram_rden_s   = 1'b0;
        ram_wren_s   = 1'b0;
        ram_addr_s   = av_address;
        ram_wdata_s  = av_writedata;
        ram_byteen_s = av_byteenable;
        wait_s       = 1'b1;
        case (state_r)
            IDLE: begin
                if (pend_valid_s) begin
                    consume_s  = 1'b1;
                    ram_addr_s = jt_addr_s;
                    case (pend_op_s)
                        OP_WR: begin
                            ram_wren_s   = 1'b1;
                            ram_wdata_s  = pend_data_s;
                            ram_byteen_s = BE_ALL;
                        end
                        OP_RD: begin
                            ram_rden_s = 1'b1;
                            next_s     = JT_RD;
                        end
                        default: begin
                            ram_rden_s = 1'b0;
                        end
                    endcase
                end else if (av_done_r || incoming_s) begin
                    consume_s = 1'b0;
                end else if (av_write) begin
                    ram_wren_s = 1'b1;
                    wait_s     = 1'b0;
                end else if (av_read) begin
                    ram_rden_s = 1'b1;
                    next_s     = AV_RD;
                end else begin
                    wait_s = 1'b1;
                end
                // A finished Avalon read completes even if JTAG takes the port this cycle.
                if (av_done_r && av_read) begin
                    wait_s = 1'b0;
                end else begin
                    wait_s = wait_s;
                end
            end
            AV_RD:   next_s = IDLE;
            JT_RD:   next_s = IDLE;
            default: next_s = IDLE;
        endcase
        if (!reset_n) begin
            next_s     = IDLE;
            consume_s  = 1'b0;
            ram_rden_s = 1'b0;
            ram_wren_s = 1'b0;
            wait_s     = 1'b1;
        end else begin
            next_s = next_s;
        end
    end

    // State register and the two read-data capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            av_done_r     <= 1'b0;
            av_readdata_r <= {DATA_W{1'b0}};
            mon_dreg_r    <= {DATA_W{1'b0}};
        end else begin
            state_r   <= next_s;
            av_done_r <= (state_r == AV_RD);
            if (state_r == AV_RD) begin
                av_readdata_r <= ram_rdata;
            end
            if (state_r == JT_RD) begin
                mon_dreg_r <= ram_rdata;
            end
        end
    end

    assign av_readdata    = av_readdata_r;
    assign av_waitrequest = wait_s;
    assign MonDReg        = mon_dreg_r;
    assign ram_addr       = ram_addr_s;
    assign ram_wdata      = ram_wdata_s;
    assign ram_byteen     = ram_byteen_s;
    assign ram_rden       = ram_rden_s;
    assign ram_wren       = ram_wren_s;

endmodule

// File: tb/tb_chenillard_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Scoreboard bench for the OCI RAM arbiter with a behavioural 1-cycle-latency RAM.
module tb_chenillard_nios2_gen2_0_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        debugack;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tna_a;
    logic [31:0] MonDReg;
    logic        jtag_overrun;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byteen;
    logic        ram_rden, ram_wren;
    logic [31:0] ram_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] av_q[$];
    logic [31:0] mon_q[$];
    logic [31:0] mon_prev;
    bit   [31:0] mem [256];
    bit          written [256];

    always #5 clk = ~clk;

    chenillard_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .debugack(debugack), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
        .take_no_action_ocimem_a(tna_a),
        .MonDReg(MonDReg), .jtag_overrun(jtag_overrun),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteen(ram_byteen),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_rdata(ram_rdata)
    );

    // Unwritten RAM words read back as a recognisable per-address pattern.
    function automatic logic [31:0] mem_rd(input logic [7:0] a);
        return written[a] ? mem[a] : (32'hA500_0000 | {24'h000000, a});
    endfunction

    // Behavioural RAM: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= {ram_byteen[3] ? ram_wdata[31:24] : mem_rd(ram_addr)[31:24],
                              ram_byteen[2] ? ram_wdata[23:16] : mem_rd(ram_addr)[23:16],
                              ram_byteen[1] ? ram_wdata[15:8]  : mem_rd(ram_addr)[15:8],
                              ram_byteen[0] ? ram_wdata[7:0]   : mem_rd(ram_addr)[7:0]};
            written[ram_addr] <= 1'b1;
        end
        if (ram_rden) ram_rdata <= mem_rd(ram_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents read data.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_prev = MonDReg;
            end else begin
                chk("ram_strobe_excl", {31'd0, ram_rden & ram_wren}, 32'd0);
                if (av_read && !av_waitrequest) begin
                    if (av_q.size() == 0) unexpected("av_readdata", av_readdata);
                    else chk("av_readdata", av_readdata, av_q.pop_front());
                end
                if (MonDReg !== mon_prev) begin
                    if (mon_q.size() == 0) unexpected("MonDReg", MonDReg);
                    else chk("MonDReg", MonDReg, mon_q.pop_front());
                    mon_prev = MonDReg;
                end
            end
        end
    end

    task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk); #1;
        av_address = a; av_writedata = d; av_byteenable = be; av_write = 1'b1;
        @(negedge clk);
        chk("av_wr_wren", {31'd0, ram_wren}, 32'd1);
        chk("av_wr_wait", {31'd0, av_waitrequest}, 32'd0);
        chk("av_wr_addr", {24'd0, ram_addr}, {24'd0, a});
        @(posedge clk); #1;
        av_write = 1'b0;
    endtask

    task automatic av_rd(input logic [7:0] a, input logic [31:0] exp, input int lat);
        int n;
        av_q.push_back(exp);
        @(posedge clk); #1;
        av_address = a; av_read = 1'b1;
        for (n = 0; n <= 30; n++) begin
            @(negedge clk);
            if (!av_waitrequest) break;
        end
        chk("av_rd_latency", n, lat);
        @(posedge clk); #1;
        av_read = 1'b0;
    endtask

    task automatic jp(input logic b, input logic a, input logic na, input logic [37:0] d,
                      input int gap);
        @(posedge clk); #1;
        jdo = d; ta_b = b; ta_a = a; tna_a = na;
        @(posedge clk); #1;
        ta_b = 1'b0; ta_a = 1'b0; tna_a = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    function automatic logic [37:0] jd_addr(input logic [7:0] a, input logic rd);
        return ({37'd0, rd} << 34) | ({30'd0, a} << 17);
    endfunction

    function automatic logic [37:0] jd_data(input logic [31:0] d);
        return {6'd0, d} << 3;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; av_address = 8'h00; av_read = 1'b0; av_write = 1'b0;
        av_writedata = 32'h0; av_byteenable = 4'h0; debugack = 1'b0; jdo = 38'h0;
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wait", {31'd0, av_waitrequest}, 32'd1);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_readdata", av_readdata, 32'h0);
        chk("rst_overrun", {31'd0, jtag_overrun}, 32'd0);
        chk("rst_strobes", {30'd0, ram_rden, ram_wren}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Avalon write then read back: 0-cycle write, 2-cycle read.
        av_wr(8'h10, 32'hCAFE_F00D, 4'hF);
        av_rd(8'h10, 32'hCAFE_F00D, 2);

        // JTAG address load then streaming writes across the wrap point.
        debugack = 1'b1;
        jp(1'b0, 1'b1, 1'b0, jd_addr(8'hFF, 1'b0), 3);
        jp(1'b1, 1'b0, 1'b0, jd_data(32'h1111_1111), 3);
        jp(1'b1, 1'b0, 1'b0, jd_data(32'h2222_2222), 3);
        jp(1'b1, 1'b0, 1'b0, jd_data(32'h3333_3333), 3);
        chk("jwr_ff", mem_rd(8'hFF), 32'h1111_1111);
        chk("jwr_wrap0", mem_rd(8'h00), 32'h2222_2222);
        chk("jwr_next1", mem_rd(8'h01), 32'h3333_3333);
        chk("jwr_untouched2", mem_rd(8'h02), 32'hA500_0002);

        // JTAG read stream: load addr 0 with read, then two streaming reads.
        mon_q.push_back(32'h2222_2222);
        jp(1'b0, 1'b1, 1'b0, jd_addr(8'h00, 1'b1), 4);
        mon_q.push_back(32'h3333_3333);
        jp(1'b0, 1'b0, 1'b1, 38'h0, 4);
        mon_q.push_back(32'hA500_0002);
        jp(1'b0, 1'b0, 1'b1, 38'h0, 4);

        // Avalon read and JTAG read arrive together: JTAG first, Avalon 5 cycles later.
        mon_q.push_back(32'hA500_0003);
        fork
            av_rd(8'h10, 32'hCAFE_F00D, 5);
            jp(1'b0, 1'b0, 1'b1, 38'h0, 2);
        join
        chk("contention_mondreg", MonDReg, 32'hA500_0003);

        // Pulses without debugack are ignored and never flag overrun.
        debugack = 1'b0;
        jp(1'b1, 1'b0, 1'b0, jd_data(32'h5555_5555), 3);
        jp(1'b0, 1'b0, 1'b1, 38'h0, 3);
        chk("nodbg_overrun", {31'd0, jtag_overrun}, 32'd0);
        chk("nodbg_mem3", mem_rd(8'h03), 32'hA500_0003);

        // Simultaneous write and read pulses: write wins, overrun latches.
        debugack = 1'b1;
        jp(1'b1, 1'b0, 1'b1, jd_data(32'h4444_4444), 3);
        chk("coll_overrun", {31'd0, jtag_overrun}, 32'd1);
        chk("coll_mem3", mem_rd(8'h03), 32'h4444_4444);
        chk("coll_mem4", mem_rd(8'h04), 32'hA500_0004);
        repeat (5) @(posedge clk);
        chk("overrun_sticky", {31'd0, jtag_overrun}, 32'd1);

        // Reset in the middle of an Avalon read aborts it.
        @(posedge clk); #1;
        av_address = 8'h10; av_read = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_wait", {31'd0, av_waitrequest}, 32'd1);
        chk("midrst_strobes", {30'd0, ram_rden, ram_wren}, 32'd0);
        chk("midrst_mondreg", MonDReg, 32'h0);
        chk("midrst_readdata", av_readdata, 32'h0);
        chk("midrst_overrun", {31'd0, jtag_overrun}, 32'd0);
        av_read = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_wait", {31'd0, av_waitrequest}, 32'd1);

        chk("av_q_drained", av_q.size(), 32'd0);
        chk("mon_q_drained", mon_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
